bird_motion: RTL
================

Name: bird_motion

Overview:
- Vertical-motion engine for the player bird; sits directly downstream of the start-screen latch and consumes its sticky `startGame` level.
- Holds the bird at its spawn row until the game starts, then applies gravity and flap impulses on a divided game tick.
- Reports death on a floor hit or a pipe collision.
- Its row output feeds the display/collision logic.

Parameters:
- ROWS, 16: playfield height. Row 0 is the floor and row ROWS-1 is the top.
- TICK_CYCLES, 12_500_000: clk cycles per game tick. Minimum value is 2.
- START_ROW, 8: spawn row. Must be 1..ROWS-1.
- FLAP_HEIGHT, 2: rows gained per flap. Must be 1..ROWS-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startGame  in  1  level from the start latch. High means the game is running.
- flap  in  1  player button, already synchronous to clk. Level-sensitive input; the block edge-detects it internally.
- hit  in  1  pipe-collision strobe from the collision logic, sampled every cycle.
- birdRow  out  $clog2(ROWS)  current bird row.
- alive  out  1  high while in FLY.
- crashed  out  1  high while in DEAD.
- tick  out  1  one-cycle pulse per game tick, in FLY only. Other stages use it for scrolling.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - `reset` is asynchronous and active-high.
  - All state clears immediately on reset assertion, mid-game included.
- Reset values:
  - state=IDLE, birdRow=START_ROW, alive=0, crashed=0, tick=0.
  - tickCnt=0, flapPending=0, flapPrev=0.
- Flap edge detection:
  - flapPrev registers flap every cycle.
  - A rise is `flap & ~flapPrev`.
  - A rise in FLY sets flapPending.
  - Multiple rises within one tick period collapse into a single flap.
- State IDLE:
  - Hold birdRow=START_ROW and tickCnt=0.
  - Flap rises are ignored.
  - startGame=1 → FLY on the next edge.
- State FLY:
  - alive=1.
  - tickCnt counts 0..TICK_CYCLES-1 and wraps.
  - tick=1 on the cycle tickCnt==TICK_CYCLES-1, so the first tick arrives TICK_CYCLES cycles after entering FLY.
  - On the tick edge:
    - If flapPending: birdRow = min(birdRow+FLAP_HEIGHT, ROWS-1), saturating at the top with no wrap. Then clear flapPending.
    - Else if birdRow>1: birdRow -= 1.
    - Else (birdRow is 0 or 1, no flap): birdRow=0 and go to DEAD.
  - A flap rise on the same cycle as the tick counts for that tick: it is OR-ed into the pending flag before the update.
  - The width arithmetic uses one extra bit for the addition so saturation is exact.
- Pipe collisions:
  - hit=1 in FLY → DEAD on the next edge, with birdRow frozen.
  - hit takes priority over a simultaneous tick update: birdRow is not changed that cycle.
- startGame falling in FLY → IDLE, which resets birdRow to START_ROW. This is a defensive path; the upstream latch normally never falls without reset.
- State DEAD:
  - crashed=1, alive=0, tick=0.
  - birdRow holds.
  - flap, hit and startGame are ignored.
  - Exits only via reset.
- Outputs alive, crashed and tick are decoded from registered state and counter (no input-to-output combinational path).

Optional Feature:
- Macro: BIRD_GRAVITY_ACCEL_EN.
- Defined:
  - A 2-bit fall-velocity register vel (reset 1) is added.
  - Each non-flap tick subtracts vel, then saturates vel at 3.
  - A flap tick resets vel to 1.
  - If birdRow ≤ vel on a falling tick, birdRow=0 and the block goes to DEAD.
- Undefined: constant fall of 1 row per tick, exactly as specified above.

Test Plan (ROWS=8, TICK_CYCLES=4, START_ROW=4, FLAP_HEIGHT=2, macro undefined unless noted):
- Reset, then startGame=0 for 20 cycles → birdRow=4, alive=0, tick never pulses; flap pulses leave birdRow=4.
- startGame=1, no flap → tick every 4 cycles; birdRow 4→3→2→1; the 4th tick gives birdRow=0, crashed=1, alive=0; birdRow stays 0 afterwards.
- In FLY at birdRow=4: three flap rises within one tick period → a single +2 (birdRow=6); another flap at the next tick → saturates at 7; the following tick with no flap → 6.
- hit=1 asserted on the same cycle as tick at birdRow=5 → DEAD, birdRow stays 5, later flaps ignored.
- Assert reset asynchronously mid-FLY between clk edges → outputs return to reset values before the next edge; after release with startGame=1, first tick arrives 4 cycles after FLY entry.
- BIRD_GRAVITY_ACCEL_EN defined, start at row 7 via flaps then no flaps → birdRow 7→6→4→1→DEAD at the following tick.

Source files
------------

// File: rtl/bird_motion.sv
// Vertical-motion engine for the player bird.
//
// Holds the bird at its spawn row until the start latch goes high. Once running, it applies
// gravity and flap impulses once per divided game tick, and reports death on a floor hit or a
// pipe collision.
//
// Optional build macro:
//   BIRD_GRAVITY_ACCEL_EN - adds a 2-bit fall velocity. The bird falls faster on consecutive
//                           non-flap ticks (1, 2, 3 rows per tick). A flap resets it to 1.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   startGame in   sticky start level; high while the game runs
//   flap      in   player button level, synchronous to clk (edge-detected here)
//   hit       in   pipe-collision strobe, sampled every cycle
//   birdRow   out  current bird row (0 = floor, ROWS-1 = top)
//   alive     out  high while flying
//   crashed   out  high while dead
//   tick      out  one-cycle game-tick pulse, only while flying
module bird_motion #(
  parameter int unsigned ROWS        = 16,
  parameter int unsigned TICK_CYCLES = 12_500_000,
  parameter int unsigned START_ROW   = 8,
  parameter int unsigned FLAP_HEIGHT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startGame,
  input  logic                    flap,
  input  logic                    hit,
  output logic [$clog2(ROWS)-1:0] birdRow,
  output logic                    alive,
  output logic                    crashed,
  output logic                    tick
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(TICK_CYCLES);

  localparam logic [RW-1:0] StartRowL = RW'(START_ROW);
  localparam logic [RW-1:0] TopRow    = RW'(ROWS - 1);
  localparam logic [RW:0]   TopRowW   = (RW+1)'(ROWS - 1);
  localparam logic [RW:0]   FlapW     = (RW+1)'(FLAP_HEIGHT);
  localparam logic [CW-1:0] CntLast   = CW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StFly, StDead} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          flap_prev_q;

  logic          rise;
  logic          at_tick;
  logic          pending_now;
  logic [RW:0]   raised;

`ifdef BIRD_GRAVITY_ACCEL_EN
  logic [1:0]    vel_q, vel_d;
`endif

  assign rise        = flap & ~flap_prev_q;
  assign at_tick     = (cnt_q == CntLast);
  // A rise on the tick cycle itself counts for that tick.
  assign pending_now = pending_q | rise;
  // One extra bit so the saturation compare cannot be fooled by wrap.
  assign raised      = {1'b0, row_q} + FlapW;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
`ifdef BIRD_GRAVITY_ACCEL_EN
    vel_d     = vel_q;
`endif
    unique case (state_q)
      StIdle: begin
        row_d     = StartRowL;
        cnt_d     = '0;
        pending_d = 1'b0;
`ifdef BIRD_GRAVITY_ACCEL_EN
        vel_d     = 2'd1;
`endif
        if (startGame) begin
          state_d = StFly;
        end
      end
      StFly: begin
        if (hit) begin
          // Collision wins over any tick update; the row freezes where it is.
          state_d = StDead;
        end else if (!startGame) begin
          state_d   = StIdle;
          row_d     = StartRowL;
          cnt_d     = '0;
          pending_d = 1'b0;
        end else if (at_tick) begin
          cnt_d     = '0;
          pending_d = 1'b0;
          if (pending_now) begin
            row_d = (raised > TopRowW) ? TopRow : raised[RW-1:0];
`ifdef BIRD_GRAVITY_ACCEL_EN
            vel_d = 2'd1;
`endif
          end else begin
`ifdef BIRD_GRAVITY_ACCEL_EN
            if (row_q <= RW'(vel_q)) begin
              row_d   = '0;
              state_d = StDead;
            end else begin
              row_d = row_q - RW'(vel_q);
              vel_d = (vel_q == 2'd3) ? 2'd3 : vel_q + 2'd1;
            end
`else
            if (row_q > RW'(1)) begin
              row_d = row_q - RW'(1);
            end else begin
              row_d   = '0;
              state_d = StDead;
            end
`endif
          end
        end else begin
          cnt_d     = cnt_q + CW'(1);
          pending_d = pending_now;
        end
      end
      StDead: begin
        // Terminal until reset.
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      row_q       <= StartRowL;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      flap_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      flap_prev_q <= flap;
    end
  end

`ifdef BIRD_GRAVITY_ACCEL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vel_q <= 2'd1;
    end else begin
      vel_q <= vel_d;
    end
  end
`endif

  // Outputs decode registered state only.
  always_comb begin
    birdRow = row_q;
    alive   = (state_q == StFly);
    crashed = (state_q == StDead);
    tick    = (state_q == StFly) && at_tick;
  end

endmodule
